fd_pipe_reg: RTL and testbench

- Fetch/decode pipeline register between the fetch-stage PC unit and the decode stage of the 5-stage MIPS pipeline.
- Captures the fetched PC and instruction, and supports stall (hold) and flush (bubble).
- Checks the fetch address and tags address errors (AdEL). Tracks the branch-delay-slot flag.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/fd_pipe_reg.sv | 127 ++++++++++++
 tb/tb_fd_pipe_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: fetch/decode pipeline register for the 5-stage MIPS pipeline.
//
// This register captures the fetched PC and instruction word. It supports the
// following actions:
//   - stall: hold the current contents.
//   - flush: insert a bubble.
//   - address check: tag illegal fetch addresses with the AdEL code.
//
// It also keeps saturating counters of stall and flush cycles.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   reset      in   synchronous, active-low reset (0 = reset)
//   stall      in   hold D-stage contents
//   flush      in   replace D-stage contents with a bubble (wins over stall)
//   bd_in      in   fetched instruction sits in a branch delay slot
//   F_PC       in   [31:0] PC of the instruction being fetched
//   F_instr    in   [31:0] instruction word read at F_PC
//   D_PC       out  [31:0] registered PC
//   D_instr    out  [31:0] registered instruction (0 = nop)
//   D_excCode  out  [4:0]  registered exception code (0 = none)
//   D_bd       out  registered delay-slot flag
//   D_valid    out  1 = real instruction, 0 = bubble
//   stall_cnt  out  [31:0] stalled cycles, saturating
//   flush_cnt  out  [31:0] flush cycles, saturating

module fd_pipe_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        bd_in,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_instr,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic [4:0]  D_excCode,
    output logic        D_bd,
    output logic        D_valid,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [4:0]  exc_q, exc_d;
    logic        bd_q, bd_d;
    logic        valid_q, valid_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic adel;

    // Misaligned or outside the instruction memory window (unsigned compares).
    assign adel = (F_PC[1:0] != 2'b00) || (F_PC < IM_BASE) || (F_PC > IM_LIMIT);

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        exc_d       = exc_q;
        bd_d        = bd_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            // Bubble keeps the PC so a later exception can still report an EPC.
            pc_d    = F_PC;
            instr_d = 32'h0;
            exc_d   = 5'd0;
            bd_d    = 1'b0;
            valid_d = 1'b0;
            if (flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end else if (stall) begin
            if (stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end else begin
            pc_d    = F_PC;
            bd_d    = bd_in;
            valid_d = 1'b1;
            if (adel) begin
                instr_d = 32'h0;
                exc_d   = EXC_ADEL;
            end else begin
                instr_d = F_instr;
                exc_d   = 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q        <= PC_RESET;
            instr_q     <= 32'h0;
            exc_q       <= 5'd0;
            bd_q        <= 1'b0;
            valid_q     <= 1'b0;
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            exc_q       <= exc_d;
            bd_q        <= bd_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign D_PC      = pc_q;
    assign D_instr   = instr_q;
    assign D_excCode = exc_q;
    assign D_bd      = bd_q;
    assign D_valid   = valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Self-checking bench for fd_pipe_reg: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the D-stage contents.

module tb_fd_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        bd_in;
    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic [4:0]  D_excCode;
    logic        D_bd;
    logic        D_valid;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_stall, m_flush;
    logic [4:0]  m_exc;
    logic        m_bd, m_valid;

    fd_pipe_reg dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .bd_in     (bd_in),
        .F_PC      (F_PC),
        .F_instr   (F_instr),
        .D_PC      (D_PC),
        .D_instr   (D_instr),
        .D_excCode (D_excCode),
        .D_bd      (D_bd),
        .D_valid   (D_valid),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic bit pc_legal(input logic [31:0] pc);
        return (pc % 4 == 0) && (pc >= 32'h0000_3000) && (pc <= 32'h0000_6FFC);
    endfunction

    // Apply one clock edge's worth of rules to the model.
    task automatic model_edge();
        if (!reset) begin
            m_pc = 32'h3000; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
            m_stall = 0; m_flush = 0;
        end else if (flush) begin
            m_pc = F_PC; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
            if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        end else if (stall) begin
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        end else begin
            m_pc = F_PC; m_bd = bd_in; m_valid = 1;
            if (pc_legal(F_PC)) begin
                m_instr = F_instr; m_exc = 0;
            end else begin
                m_instr = 0; m_exc = 5'd4;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".pc"},    D_PC,      m_pc);
        check_val({tag, ".instr"}, D_instr,   m_instr);
        check_val({tag, ".exc"},   {27'd0, D_excCode}, {27'd0, m_exc});
        check_val({tag, ".bd"},    {31'd0, D_bd},      {31'd0, m_bd});
        check_val({tag, ".valid"}, {31'd0, D_valid},   {31'd0, m_valid});
        check_val({tag, ".scnt"},  stall_cnt, m_stall);
        check_val({tag, ".fcnt"},  flush_cnt, m_flush);
    endtask

    // Drive inputs, take one edge, update model, sample 1 time unit later.
    task automatic step(input logic rst, input logic st, input logic fl, input logic bd,
                        input logic [31:0] pc, input logic [31:0] ins, input string tag);
        reset = rst; stall = st; flush = fl; bd_in = bd; F_PC = pc; F_instr = ins;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] edges [4];
        edges[0] = 32'h2FFC; edges[1] = 32'h3000; edges[2] = 32'h6FFC; edges[3] = 32'h7000;
        case ($urandom_range(0, 5))
            0:       return edges[$urandom_range(0, 3)];
            1:       return 32'h3000 + ($urandom_range(0, 4095) * 4) + $urandom_range(1, 3);
            2:       return $urandom();
            default: return 32'h3000 + $urandom_range(0, 4095) * 4;
        endcase
    endfunction

    initial begin
        m_pc = 0; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_stall = 0; m_flush = 0;

        // 1: reset for two cycles, then release
        step(0, 0, 0, 0, 32'h3010, 32'h1111_1111, "rst0");
        step(0, 0, 0, 0, 32'h3010, 32'h1111_1111, "rst1");
        check_val("rst.pc_const", D_PC, 32'h3000);
        step(1, 0, 0, 0, 32'h3010, 32'h1111_1111, "rel");
        check_val("rel.valid_const", {31'd0, D_valid}, 32'd1);

        // 2: normal load with delay slot, then 3 stall cycles
        step(1, 0, 0, 1, 32'h3004, 32'h3C01_1234, "load");
        check_val("load.instr_const", D_instr, 32'h3C01_1234);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h3008, $urandom(), "stall");
        check_val("stall.cnt_const", stall_cnt, 32'd3);
        check_val("stall.instr_const", D_instr, 32'h3C01_1234);

        // 3: address errors and the inclusive upper boundary
        step(1, 0, 0, 0, 32'h3006, 32'hFFFF_FFFF, "mis");
        check_val("mis.exc_const", {27'd0, D_excCode}, 32'd4);
        step(1, 0, 0, 0, 32'h2FFC, 32'hFFFF_FFFF, "low");
        step(1, 0, 0, 0, 32'h7000, 32'hFFFF_FFFF, "high");
        check_val("high.instr_const", D_instr, 32'h0);
        step(1, 0, 0, 0, 32'h6FFC, 32'hFFFF_FFFF, "limit");
        check_val("limit.instr_const", D_instr, 32'hFFFF_FFFF);
        step(1, 0, 0, 0, 32'h3000, 32'h0123_4567, "base");

        // 4: flush beats stall
        step(1, 1, 1, 1, 32'h3020, 32'hDEAD_BEEF, "fl_st");
        check_val("fl_st.fcnt_const", flush_cnt, 32'd1);
        check_val("fl_st.scnt_const", stall_cnt, 32'd3);

        // 5: stall counter saturation
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        m_stall = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h3024, $urandom(), "sat");
        check_val("sat.const", stall_cnt, 32'hFFFF_FFFF);

        // 6: reset in the middle of a stall with a valid instruction held
        step(1, 0, 0, 0, 32'h3040, 32'h2408_0005, "pre6");
        step(1, 1, 0, 0, 32'h3044, 32'h0, "mid6");
        step(0, 1, 0, 1, 32'h3044, 32'h0, "rst6");
        check_val("rst6.scnt_const", stall_cnt, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 rand_pc(), $urandom(), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
